// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length/data/checksum frame from the UART
// byte stream, writes words into imem, and holds the CPU in reset until the frame checks out.
module imem_loader #(
  parameter int WORD   = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, SUM, DONE, ERR} state_e;

  state_e            state_q;
  logic [1:0]        bcnt_q;
  logic [23:0]       asm_q;
  logic [31:0]       len_q;
  logic [ADDR_W-1:0] widx_q;
  logic [7:0]        csum_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic [31:0]       word_d;
  logic [ADDR_W-1:0] last_idx;

  assign in_ready = (state_q == LEN) || (state_q == DATA) || (state_q == SUM);
  assign accept   = in_valid && in_ready;
  // Current byte completes a little-endian word with the three held below it.
  assign word_d   = {in_data, asm_q};
  // N <= 2**ADDR_W, so N-1 always fits the index width (N == 2**ADDR_W wraps to all-ones).
  assign last_idx = ADDR_W'(len_q - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      asm_q       <= '0;
      len_q       <= '0;
      widx_q      <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q   <= LEN;
          bcnt_q    <= '0;
          asm_q     <= '0;
          len_q     <= '0;
          widx_q    <= '0;
          csum_q    <= '0;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
        end
        LEN: if (accept) begin
          bcnt_q <= bcnt_q + 2'd1;
          asm_q  <= {in_data, asm_q[23:8]};
          if (bcnt_q == 2'd3) begin
            len_q <= word_d;
            if (word_d > 32'(WORD)) begin
              state_q <= ERR;
              error_q <= 1'b1;
            end else if (word_d == 32'd0) begin
              state_q <= SUM;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: if (accept) begin
          bcnt_q <= bcnt_q + 2'd1;
          asm_q  <= {in_data, asm_q[23:8]};
          csum_q <= csum_q ^ in_data;
          if (bcnt_q == 2'd3) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= widx_q;
            mem_wdata_q <= word_d;
            widx_q      <= widx_q + 1'b1;
            if (widx_q == last_idx) state_q <= SUM;
          end
        end
        SUM: if (accept) begin
          if (in_data == csum_q) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            cpu_rst_q <= 1'b0;
          end else begin
            state_q <= ERR;
            error_q <= 1'b1;
          end
        end
        DONE, ERR: if (start) begin
          state_q   <= IDLE;
          cpu_rst_q <= 1'b1;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
